// File: rtl/bit32_rf_pkg.sv
// Shared constants and operation encoding for the 16x32 register file with integrated ALU.
package bit32_rf_pkg;

    localparam int WIDTH = 32;
    localparam int NREGS = 16;
    localparam int AW    = $clog2(NREGS);

    typedef enum logic [3:0] {
        MODE_NOP = 4'd0,
        MODE_ADD = 4'd1,
        MODE_SUB = 4'd2,
        MODE_AND = 4'd3,
        MODE_OR  = 4'd4,
        MODE_XOR = 4'd5,
        MODE_NOT = 4'd6,
        MODE_SHL = 4'd7,
        MODE_SHR = 4'd8,
        MODE_MOV = 4'd9
    } mode_e;

endpackage

// File: rtl/rf_alu.sv
// Combinational ALU: computes the write-back value, write enable and next carry flag for one operation.
module rf_alu
    import bit32_rf_pkg::*;
(
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       mode_i,
    input  logic             cy_i,
    output logic [WIDTH-1:0] result_o,
    output logic             we_o,
    output logic             cy_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // Subtraction as A + ~B + 1 so the top bit is a carry (1 means no borrow).
    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        result_o = '0;
        we_o     = 1'b0;
        cy_o     = cy_i;
        case (mode_e'(mode_i))
            MODE_ADD: begin
                result_o = sum[WIDTH-1:0];
                we_o     = 1'b1;
                cy_o     = sum[WIDTH];
            end
            MODE_SUB: begin
                result_o = diff[WIDTH-1:0];
                we_o     = 1'b1;
                cy_o     = diff[WIDTH];
            end
            MODE_AND: begin
                result_o = a_i & b_i;
                we_o     = 1'b1;
                cy_o     = 1'b0;
            end
            MODE_OR: begin
                result_o = a_i | b_i;
                we_o     = 1'b1;
                cy_o     = 1'b0;
            end
            MODE_XOR: begin
                result_o = a_i ^ b_i;
                we_o     = 1'b1;
                cy_o     = 1'b0;
            end
            MODE_NOT: begin
                result_o = ~a_i;
                we_o     = 1'b1;
                cy_o     = 1'b0;
            end
            MODE_SHL: begin
                result_o = {a_i[WIDTH-2:0], 1'b0};
                we_o     = 1'b1;
                cy_o     = a_i[WIDTH-1];
            end
            MODE_SHR: begin
                result_o = {1'b0, a_i[WIDTH-1:1]};
                we_o     = 1'b1;
                cy_o     = a_i[0];
            end
            MODE_MOV: begin
                result_o = a_i;
                we_o     = 1'b1;
            end
            default: begin
                result_o = '0;
                we_o     = 1'b0;
                cy_o     = cy_i;
            end
        endcase
    end

endmodule

// File: rtl/bit32_register_file.sv
// 16x32 register file with a single-write-port 3-operand ALU; R[Rz] <= R[Rx] op R[Ry] each clock.
// Optional macro RF_READ_PORT_EN adds the Rout debug port showing R[Rz].
module bit32_register_file
    import bit32_rf_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH*NREGS-1:0] D,
    input  logic [3:0]             Mode,
    input  logic [AW-1:0]          Rx,
    input  logic [AW-1:0]          Ry,
    input  logic [AW-1:0]          Rz,
`ifdef RF_READ_PORT_EN
    output logic [WIDTH-1:0]       Rout,
`endif
    output logic                   Cy
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic             cy_q;
    logic             cy_d;
    logic [WIDTH-1:0] alu_result;
    logic             alu_we;

    rf_alu u_alu (
        .a_i      (regs_q[Rx]),
        .b_i      (regs_q[Ry]),
        .mode_i   (Mode),
        .cy_i     (cy_q),
        .result_o (alu_result),
        .we_o     (alu_we),
        .cy_o     (cy_d)
    );

    // Low reset is an asynchronous load of the whole array from D, repeated every edge while held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= D[i*WIDTH +: WIDTH];
            end
            cy_q <= 1'b0;
        end else begin
            if (alu_we) begin
                regs_q[Rz] <= alu_result;
            end
            cy_q <= cy_d;
        end
    end

    assign Cy = cy_q;

`ifdef RF_READ_PORT_EN
    assign Rout = regs_q[Rz];
`endif

endmodule

// File: tb/tb_bit32_register_file.sv
// Self-checking bench for bit32_register_file: directed test-plan steps then random ops against an array model.
module tb_bit32_register_file;
    import bit32_rf_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] D;
    logic [3:0]   Mode;
    logic [3:0]   Rx;
    logic [3:0]   Ry;
    logic [3:0]   Rz;
    logic         Cy;
`ifdef RF_READ_PORT_EN
    logic [31:0]  Rout;
`endif

    int unsigned model [16];
    bit          modelCy;
    int          compared   = 0;
    int          mismatched = 0;

    bit32_register_file dut (
        .clk  (clk),
        .rst  (rst),
        .D    (D),
        .Mode (Mode),
        .Rx   (Rx),
        .Ry   (Ry),
        .Rz   (Rz),
`ifdef RF_READ_PORT_EN
        .Rout (Rout),
`endif
        .Cy   (Cy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, expected);
        end
    endtask

    task automatic checkState(input string tag);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("%s_R%0d", tag, i), dut.regs_q[i], model[i]);
        end
        checkOutput({tag, "_Cy"}, {31'b0, Cy}, {31'b0, modelCy});
    endtask

    task automatic loadModelFromD();
        for (int i = 0; i < 16; i++) begin
            model[i] = D[i*32 +: 32];
        end
        modelCy = 1'b0;
    endtask

    // Drive one operation at a falling edge, let one rising edge pass, then compare everything.
    task automatic applyStimulus(input int mode, input int rx, input int ry, input int rz, input string tag);
        int unsigned a;
        int unsigned b;
        int unsigned res;
        longint      s;
        bit          wr;
        bit          cy;
        Mode = 4'(mode);
        Rx   = 4'(rx);
        Ry   = 4'(ry);
        Rz   = 4'(rz);
`ifdef RF_READ_PORT_EN
        #1;
        checkOutput({tag, "_Rout"}, Rout, model[rz]);
`endif
        a   = model[rx];
        b   = model[ry];
        res = 0;
        wr  = 1'b1;
        cy  = modelCy;
        case (mode)
            1: begin
                s   = longint'(a) + longint'(b);
                res = 32'(s);
                cy  = (s >= 64'h1_0000_0000);
            end
            2: begin
                res = a - b;
                cy  = (a >= b);
            end
            3: begin res = a & b; cy = 1'b0; end
            4: begin res = a | b; cy = 1'b0; end
            5: begin res = a ^ b; cy = 1'b0; end
            6: begin res = ~a;    cy = 1'b0; end
            7: begin
                res = a * 2;
                cy  = (a >= 32'h8000_0000);
            end
            8: begin
                res = a / 2;
                cy  = (a % 2) == 1;
            end
            9: res = a;
            default: wr = 1'b0;
        endcase
        @(negedge clk);
        if (wr) model[rz] = res;
        modelCy = cy;
        checkState(tag);
    endtask

    initial begin
        rst  = 1'b1;
        D    = '0;
        Mode = 4'd0;
        Rx   = 4'd0;
        Ry   = 4'd0;
        Rz   = 4'd0;
        D[0*32 +: 32]  = 32'h0000_0007;
        D[1*32 +: 32]  = 32'h0000_0001;
        D[15*32 +: 32] = 32'hFFFF_FFFF;
        #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        loadModelFromD();
        checkState("resetLoad");
        checkOutput("resetR15", dut.regs_q[15], 32'hFFFF_FFFF);
        rst = 1'b1;
        D   = {16{32'hDEAD_BEEF}};

        applyStimulus(9, 0, 0, 2, "movR2");
        checkOutput("movR2Lit", dut.regs_q[2], 32'h0000_0007);
        applyStimulus(1, 15, 1, 10, "addCarry");
        checkOutput("addCarryR10", dut.regs_q[10], 32'h0);
        checkOutput("addCarryCy", {31'b0, Cy}, 32'd1);
        applyStimulus(1, 0, 1, 11, "addNoCarry");
        checkOutput("addNoCarryR11", dut.regs_q[11], 32'h0000_0008);
        applyStimulus(2, 1, 0, 6, "subBorrow");
        checkOutput("subBorrowR6", dut.regs_q[6], 32'hFFFF_FFFA);
        checkOutput("subBorrowCy", {31'b0, Cy}, 32'd0);
        applyStimulus(2, 0, 1, 6, "subNoBorrow");
        checkOutput("subNoBorrowR6", dut.regs_q[6], 32'h0000_0006);
        checkOutput("subNoBorrowCy", {31'b0, Cy}, 32'd1);
        applyStimulus(1, 0, 0, 0, "alias1");
        checkOutput("alias1R0", dut.regs_q[0], 32'h0000_000E);
        applyStimulus(1, 0, 0, 0, "alias2");
        checkOutput("alias2R0", dut.regs_q[0], 32'h0000_001C);

        // Build 0x80000001 in R12 from R15 and R1, then exercise the shifts.
        applyStimulus(8, 15, 0, 12, "shrAllOnes");
        applyStimulus(6, 12, 0, 12, "not");
        applyStimulus(1, 12, 1, 12, "build");
        checkOutput("buildR12", dut.regs_q[12], 32'h8000_0001);
        applyStimulus(7, 12, 0, 13, "shl");
        checkOutput("shlR13", dut.regs_q[13], 32'h0000_0002);
        checkOutput("shlCy", {31'b0, Cy}, 32'd1);
        applyStimulus(1, 1, 1, 3, "make2");
        applyStimulus(1, 3, 1, 3, "make3");
        applyStimulus(8, 3, 0, 4, "shr");
        checkOutput("shrR4", dut.regs_q[4], 32'h0000_0001);
        checkOutput("shrCy", {31'b0, Cy}, 32'd1);
        applyStimulus(9, 2, 0, 0, "restoreR0");
        applyStimulus(5, 15, 0, 5, "xor");
        checkOutput("xorR5", dut.regs_q[5], 32'hFFFF_FFF8);
        checkOutput("xorCy", {31'b0, Cy}, 32'd0);
        applyStimulus(7, 12, 0, 14, "setCy");
        applyStimulus(12, 3, 4, 5, "mode12");
        checkOutput("mode12Cy", {31'b0, Cy}, 32'd1);
        for (int m = 10; m < 16; m++) begin
            applyStimulus(m, m, 0, m - 8, "unusedMode");
        end

        for (int n = 0; n < 200; n++) begin
            applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), "rand");
        end

        // Reset dropped between edges must reload from D at once.
        for (int i = 0; i < 16; i++) begin
            D[i*32 +: 32] = $urandom;
        end
        #2;
        rst = 1'b0;
        #1;
        loadModelFromD();
        checkState("asyncRst");
        @(negedge clk);
        checkState("rstHeld");
        rst = 1'b1;
        D   = '1;
        for (int n = 0; n < 60; n++) begin
            applyStimulus(int'($urandom_range(0, 9)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), "postRst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bit32_register_file.md
Name: bit32_register_file

Overview:
- 16-entry × 32-bit register file with an integrated 3-operand ALU.
- Each clock it computes R[Rz] <= R[Rx] op R[Ry], with op selected by Mode, and registers the carry/borrow flag Cy.
- The register file initial contents are loaded from the flat input D while reset is asserted.
- Used as the datapath core for register-operation exercises.

Parameters:
- WIDTH, 32, data width of each register.
- NREGS, 16, number of registers; the address width is log2(NREGS) = 4.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; loads the register file from D.
- D  input  WIDTH*NREGS (512)  initial contents; R[i] = D[32*i+31 : 32*i].
- Mode  input  4  operation select.
- Rx  input  4  source A index.
- Ry  input  4  source B index.
- Rz  input  4  destination index.
- Cy  output  1  registered carry/borrow/shift-out flag.

Behaviour:
- Reset: while rst=0, every R[i] is asynchronously loaded from its D slice and Cy=0. The load is held for as long as rst stays low. After rst rises, D is ignored.
- Operation: on each rising clk edge with rst=1, A=R[Rx] and B=R[Ry] are sampled pre-edge. R[Rz] is written and Cy updated per Mode:
  - 0 NOP: no write; Cy holds.
  - 1 ADD: R[Rz]=A+B mod 2^32; Cy = bit 32 of the 33-bit sum.
  - 2 SUB: R[Rz]=A-B mod 2^32; Cy = carry out of A+~B+1 (1 = no borrow, i.e. A>=B unsigned).
  - 3 AND, 4 OR, 5 XOR: bitwise A op B; Cy=0.
  - 6 NOT: R[Rz]=~A; Cy=0.
  - 7 SHL: R[Rz]=A<<1; Cy=A[31].
  - 8 SHR (logical): R[Rz]=A>>1; Cy=A[0].
  - 9 MOV: R[Rz]=A; Cy holds.
  - 10–15: treated as NOP.
- Latency: one cycle; the result is visible in R[Rz] and Cy after the edge.
- Aliasing: Rx, Ry and Rz may be equal. Operands are always the pre-edge values; for example Rx=Ry=Rz with ADD doubles the register.
- Single write port; only R[Rz] changes per cycle. Other registers hold.
- Reset asserted mid-operation immediately overrides any pending write and reloads all registers from D.

Optional Feature:
- Macro RF_READ_PORT_EN.
- When defined: adds output Rout [31:0], combinationally equal to R[Rz] (current contents, pre-write), for observation and debug.
- When undefined: no extra port; state is visible only through Cy.

Decomposition:
- Package bit32_rf_pkg holds:
  - WIDTH, NREGS, and the address width;
  - a 4-bit mode typedef with constants MODE_NOP, MODE_ADD, MODE_SUB, MODE_AND, MODE_OR, MODE_XOR, MODE_NOT, MODE_SHL, MODE_SHR, MODE_MOV.
- One sub-module, rf_alu: purely combinational (A, B, Mode, Cy_in) -> (result, write_en, Cy_next).
- The top level holds the register array and Cy flop.

Test Plan:
- Reset load: D with R0=0x00000007, R1=0x00000001, R15=0xFFFFFFFF, others 0; hold rst=0 two cycles -> Cy=0; after release, MOV R2<-R0 gives R2=0x00000007.
- ADD carry: Mode=1, Rx=15, Ry=1, Rz=10 -> R10=0x00000000, Cy=1; then Rx=0, Ry=1, Rz=11 -> R11=0x00000008, Cy=0.
- SUB borrow: Mode=2, Rx=1 (1), Ry=0 (7), Rz=6 -> R6=0xFFFFFFFA, Cy=0; then Rx=0, Ry=1 -> R6=0x00000006, Cy=1.
- Aliasing: Mode=1, Rx=Ry=Rz=0 with R0=7 -> R0=0x0000000E after one edge, 0x0000001C after the next.
- Shifts/logic: SHL of 0x80000001 -> 0x00000002, Cy=1; SHR of 0x00000003 -> 0x00000001, Cy=1; XOR of R15 with R0 (R0=7) -> 0xFFFFFFF8, Cy=0; Mode=12 -> no register change, Cy held.
- Async reset mid-run: assert rst=0 between clock edges after several ops -> all registers revert to their D values and Cy=0 immediately, without waiting for a clock edge.
